// File: rtl/segment_pkg.sv
// Shared definitions for 128-bit clock-segment records: field layout, wait-record
// control bits and validity helpers used by the packer and the clock generator.
package segment_pkg;

  localparam int unsigned SEG_W     = 128;
  localparam int unsigned ON_LSB    = 80;
  localparam int unsigned ON_MSB    = 127;
  localparam int unsigned OFF_LSB   = 32;
  localparam int unsigned OFF_MSB   = 79;
  localparam int unsigned REP_LSB   = 0;
  localparam int unsigned REP_MSB   = 31;
  localparam int unsigned EDGE_BIT  = 0;
  localparam int unsigned LEVEL_BIT = 1;

  typedef struct packed {
    logic [ON_MSB-ON_LSB:0]   on_counts;
    logic [OFF_MSB-OFF_LSB:0] off_counts;
    logic [REP_MSB-REP_LSB:0] repeat_counts;
  } segment_t;

  // A zero repeat count marks a wait-for-retrigger record.
  function automatic logic is_wait_segment(input segment_t rec);
    return rec.repeat_counts == '0;
  endfunction

  function automatic logic is_malformed(input segment_t rec);
    return !is_wait_segment(rec) &&
           ((rec.on_counts == '0) || (rec.off_counts == '0));
  endfunction

  function automatic logic wait_edge_mode(input segment_t rec);
    return rec.off_counts[EDGE_BIT];
  endfunction

  function automatic logic wait_trigger_level(input segment_t rec);
    return rec.off_counts[LEVEL_BIT];
  endfunction

endpackage

// File: rtl/segment_checker.sv
// Combinational record validator: flags segments with a repeat count but no on/off time.
module segment_checker
  import segment_pkg::*;
(
  input  segment_t rec_i,
  output logic     malformed_c
);

  assign malformed_c = is_malformed(rec_i);

endmodule

// File: rtl/segment_packer.sv
// Packs eight 16-bit pipe words into a 128-bit segment record, validates it and
// forwards it through a one-entry holding register to the segment FIFO.
module segment_packer
  import segment_pkg::*;
#(
  parameter int unsigned WORDS_PER_SEG  = 8,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned CHECK_SEGMENTS = 1
) (
  input  logic              ti_clk,
  input  logic              reset_n,
  input  logic              pipe_write,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              flush,
  input  logic              clear_status,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [SEG_W-1:0]  fifo_din,
  output logic [2:0]        word_index,
  output logic              partial,
  output logic [15:0]       seg_count,
  output logic [15:0]       bad_count,
  output logic              overflow
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned BUF_W = SEG_W - DATA_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_SEG - 1);

  logic [IDX_W-1:0] word_q, word_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  segment_t         hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [CNT_W-1:0] seg_q, seg_d;
  logic [CNT_W-1:0] bad_q, bad_d;
  logic             overflow_q, overflow_d;

  segment_t rec_c;
  logic     malformed_c;
  logic     accept_c;
  logic     complete_c;
  logic     reject_c;
  logic     wr_c;

  // Last word bypasses the buffer so the record is judged at the edge it arrives.
  assign rec_c = segment_t'({pipe_data, buf_q});

  segment_checker u_checker (
    .rec_i       (rec_c),
    .malformed_c (malformed_c)
  );

  assign accept_c   = pipe_write & ~flush;
  assign complete_c = accept_c && (word_q == LAST_IDX);
  assign reject_c   = complete_c && malformed_c && (CHECK_SEGMENTS != 0);
  assign wr_c       = hold_valid_q & ~fifo_full & ~flush;

  always_comb begin
    word_d       = word_q;
    buf_d        = buf_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    seg_d        = seg_q;
    bad_d        = bad_q;
    overflow_d   = overflow_q;

    if (accept_c) begin
      word_d = complete_c ? '0 : word_q + IDX_W'(1);
    end

    for (int unsigned k = 0; k < WORDS_PER_SEG - 1; k++) begin
      if (accept_c && (word_q == IDX_W'(k))) begin
        buf_d[k*DATA_W +: DATA_W] = pipe_data;
      end
    end

    if (wr_c) begin
      hold_valid_d = 1'b0;
      seg_d        = seg_q + CNT_W'(1);
    end

    if (flush) begin
      word_d       = '0;
      hold_valid_d = 1'b0;
    end

    // A record may reload the holding register on the edge it drains.
    if (complete_c && !reject_c) begin
      if (!hold_valid_q || wr_c) begin
        hold_d       = rec_c;
        hold_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (reject_c && (bad_q != '1)) begin
      bad_d = bad_q + CNT_W'(1);
    end

    if (clear_status) begin
      seg_d      = '0;
      bad_d      = '0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge ti_clk or negedge reset_n) begin
    if (!reset_n) begin
      word_q       <= '0;
      buf_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      seg_q        <= '0;
      bad_q        <= '0;
      overflow_q   <= 1'b0;
    end else begin
      word_q       <= word_d;
      buf_q        <= buf_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      seg_q        <= seg_d;
      bad_q        <= bad_d;
      overflow_q   <= overflow_d;
    end
  end

  assign fifo_wr_en = wr_c;
  assign fifo_din   = hold_q;
  assign word_index = word_q;
  assign partial    = (word_q != '0);
  assign seg_count  = seg_q;
  assign bad_count  = bad_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_segment_packer.sv
// Bench for segment_packer: two instances (checking on/off) against a word-queue model,
// plus directed scenarios with hand-computed literal expectations.
module tb_segment_packer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         pipe_write;
  logic [15:0]  pipe_data;
  logic         flush;
  logic         clear_status;
  logic         fifo_full;

  logic         wr0, wr1;
  logic [127:0] din0, din1;
  logic [2:0]   widx0, widx1;
  logic         part0, part1;
  logic [15:0]  seg0, seg1, bad0, bad1;
  logic         ovf0, ovf1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  segment_packer #(.CHECK_SEGMENTS(1)) dut0 (
    .ti_clk(clk), .reset_n(reset_n), .pipe_write(pipe_write), .pipe_data(pipe_data),
    .flush(flush), .clear_status(clear_status), .fifo_full(fifo_full),
    .fifo_wr_en(wr0), .fifo_din(din0), .word_index(widx0), .partial(part0),
    .seg_count(seg0), .bad_count(bad0), .overflow(ovf0)
  );

  segment_packer #(.CHECK_SEGMENTS(0)) dut1 (
    .ti_clk(clk), .reset_n(reset_n), .pipe_write(pipe_write), .pipe_data(pipe_data),
    .flush(flush), .clear_status(clear_status), .fifo_full(fifo_full),
    .fifo_wr_en(wr1), .fifo_din(din1), .word_index(widx1), .partial(part1),
    .seg_count(seg1), .bad_count(bad1), .overflow(ovf1)
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: index 0 checks segments, index 1 writes every segment.
  logic [127:0] m_acc  [2] = '{default: '0};
  logic [127:0] m_hold [2] = '{default: '0};
  int           m_n    [2] = '{default: 0};
  bit           m_hv   [2] = '{default: 1'b0};
  bit           m_ovf  [2] = '{default: 1'b0};
  logic [15:0]  m_seg  [2] = '{default: '0};
  logic [15:0]  m_bad  [2] = '{default: '0};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_acc[i] = '0; m_hold[i] = '0; m_n[i] = 0; m_hv[i] = 1'b0;
        m_ovf[i] = 1'b0; m_seg[i] = '0; m_bad[i] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit           written;
        bit           free;
        bit           bad;
        logic [127:0] rec;
        written = m_hv[i] && !fifo_full && !flush;
        free    = !m_hv[i] || written;
        if (written) m_seg[i] = m_seg[i] + 16'd1;
        if (written || flush) m_hv[i] = 1'b0;
        if (flush) begin
          m_n[i] = 0; m_acc[i] = '0;
        end else if (pipe_write) begin
          rec = m_acc[i] | ({112'b0, pipe_data} << (16 * m_n[i]));
          if (m_n[i] == 7) begin
            m_n[i] = 0; m_acc[i] = '0;
            bad = (rec[31:0] != 0) && ((rec[127:80] == 0) || (rec[79:32] == 0));
            if (bad && i == 0) begin
              if (m_bad[i] != 16'hFFFF) m_bad[i] = m_bad[i] + 16'd1;
            end else if (free) begin
              m_hold[i] = rec; m_hv[i] = 1'b1;
            end else begin
              m_ovf[i] = 1'b1;
            end
          end else begin
            m_acc[i] = rec; m_n[i] = m_n[i] + 1;
          end
        end
        if (clear_status) begin
          m_seg[i] = '0; m_bad[i] = '0; m_ovf[i] = 1'b0;
        end
      end
    end
  end

  task automatic cmp_inst(input int i, input logic wr, input logic [127:0] din,
                          input logic [2:0] widx, input logic part, input logic [15:0] seg,
                          input logic [15:0] bad, input logic ovf);
    check($sformatf("m%0d_wr_en", i), 128'(wr), 128'(m_hv[i] && !fifo_full && !flush));
    check($sformatf("m%0d_din", i), din, m_hold[i]);
    check($sformatf("m%0d_word_index", i), 128'(widx), 128'(m_n[i]));
    check($sformatf("m%0d_partial", i), 128'(part), 128'(m_n[i] != 0));
    check($sformatf("m%0d_seg_count", i), 128'(seg), 128'(m_seg[i]));
    check($sformatf("m%0d_bad_count", i), 128'(bad), 128'(m_bad[i]));
    check($sformatf("m%0d_overflow", i), 128'(ovf), 128'(m_ovf[i]));
  endtask

  always @(negedge clk) begin
    cmp_inst(0, wr0, din0, widx0, part0, seg0, bad0, ovf0);
    cmp_inst(1, wr1, din1, widx1, part1, seg1, bad1, ovf1);
  end

  task automatic drive(input bit pw, input logic [15:0] d, input bit fl, input bit cs);
    @(posedge clk);
    #1;
    pipe_write = pw; pipe_data = d; flush = fl; clear_status = cs;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic send_seq(input logic [15:0] base);
    for (int k = 1; k <= 8; k++) drive(1'b1, base + 16'(k), 1'b0, 1'b0);
  endtask

  task automatic send_words(input logic [15:0] w [8]);
    for (int k = 0; k < 8; k++) drive(1'b1, w[k], 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] malformed_w [8];
    logic [15:0] wait_w [8];
    malformed_w = '{16'h0005, 16'h0000, 16'h000A, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    wait_w      = '{16'h0000, 16'h0000, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

    reset_n = 1'b0; pipe_write = 1'b0; pipe_data = '0; flush = 1'b0;
    clear_status = 1'b0; fifo_full = 1'b0;
    #2;
    check("rst_wr_en", 128'(wr0), 128'h0);
    check("rst_din", din0, 128'h0);
    check("rst_word_index", 128'(widx0), 128'h0);
    check("rst_seg_count", 128'(seg0), 128'h0);
    @(posedge clk); #1; reset_n = 1'b1;

    // Basic packing and one-cycle write strobe
    send_seq(16'h0000);
    idle(); @(negedge clk);
    check("basic_wr_en", 128'(wr0), 128'h1);
    check("basic_din", din0, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    check("basic_word_index", 128'(widx0), 128'h0);
    idle(); @(negedge clk);
    check("basic_wr_en_drop", 128'(wr0), 128'h0);
    check("basic_seg_count", 128'(seg0), 128'h1);

    // Malformed record: repeat=5, on=0, off=10
    send_words(malformed_w);
    idle(); @(negedge clk);
    check("bad_no_wr", 128'(wr0), 128'h0);
    check("bad_unchecked_wr", 128'(wr1), 128'h1);
    idle(); @(negedge clk);
    check("bad_count", 128'(bad0), 128'h1);
    check("bad_seg_unchanged", 128'(seg0), 128'h1);
    check("bad_unchecked_seg", 128'(seg1), 128'h2);

    // Clear, then a wait record is accepted
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    idle(); @(negedge clk);
    check("clr_seg", 128'(seg0), 128'h0);
    check("clr_bad", 128'(bad0), 128'h0);
    send_words(wait_w);
    idle(); @(negedge clk);
    check("wait_wr_en", 128'(wr0), 128'h1);
    check("wait_din", din0, 128'h00000000_00000000_00000003_00000000);
    idle(); @(negedge clk);
    check("wait_seg", 128'(seg0), 128'h1);
    check("wait_bad", 128'(bad0), 128'h0);

    // FIFO full: first segment held, second lost
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    fifo_full = 1'b1;
    send_seq(16'h0100);
    idle(); @(negedge clk);
    check("full_hold_wr", 128'(wr0), 128'h0);
    check("full_hold_din", din0, 128'h0108_0107_0106_0105_0104_0103_0102_0101);
    send_seq(16'h0200);
    idle(); @(negedge clk);
    check("full_overflow", 128'(ovf0), 128'h1);
    check("full_still_first", din0, 128'h0108_0107_0106_0105_0104_0103_0102_0101);
    idle(); fifo_full = 1'b0; @(negedge clk);
    check("release_wr", 128'(wr0), 128'h1);
    check("release_din", din0, 128'h0108_0107_0106_0105_0104_0103_0102_0101);
    idle(); @(negedge clk);
    check("release_single", 128'(wr0), 128'h0);
    check("release_seg", 128'(seg0), 128'h1);

    // Flush discards a partial segment and the coincident word
    for (int k = 1; k <= 5; k++) drive(1'b1, 16'h0A00 + 16'(k), 1'b0, 1'b0);
    drive(1'b1, 16'h0AAA, 1'b1, 1'b0);
    idle(); @(negedge clk);
    check("flush_word_index", 128'(widx0), 128'h0);
    check("flush_partial", 128'(part0), 128'h0);
    send_seq(16'h0B00);
    idle(); @(negedge clk);
    check("flush_new_wr", 128'(wr0), 128'h1);
    check("flush_new_din", din0, 128'h0B08_0B07_0B06_0B05_0B04_0B03_0B02_0B01);
    idle(); @(negedge clk);
    check("flush_seg", 128'(seg0), 128'h2);

    // Asynchronous reset mid-segment
    for (int k = 1; k <= 3; k++) drive(1'b1, 16'h0C00 + 16'(k), 1'b0, 1'b0);
    idle();
    #1 check("mid_word_index", 128'(widx0), 128'h3);
    #1 reset_n = 1'b0;
    #1;
    check("arst_word_index", 128'(widx0), 128'h0);
    check("arst_din", din0, 128'h0);
    check("arst_seg", 128'(seg0), 128'h0);
    check("arst_overflow", 128'(ovf0), 128'h0);
    @(posedge clk); #1; reset_n = 1'b1;
    send_seq(16'h0D00);
    idle(); @(negedge clk);
    check("post_rst_wr", 128'(wr0), 128'h1);
    check("post_rst_din", din0, 128'h0D08_0D07_0D06_0D05_0D04_0D03_0D02_0D01);
    idle(); @(negedge clk);
    check("post_rst_seg", 128'(seg0), 128'h1);

    idle(); idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
